// File: rtl/spram_arbiter.sv
// spram_arbiter: shares one 64K x 16 SPRAM between the CPU port (A) and a
// secondary master (B). Round-robin arbitration with a bounded A burst,
// one registered SPRAM access per cycle, and read data routed back to the
// issuing port two cycles after the grant.
module spram_arbiter #(
  parameter int unsigned BURST_A = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_data_in,
  output logic              sram_wren,
  input  logic [DATA_W-1:0] sram_data_out
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

  owner_t           last_owner;
  owner_t           last_owner_nxt;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_cnt_nxt;
  logic             grant_a;
  logic             grant_b;

  // Read tag pipeline: stage 0 follows the grant edge, stage 1 lines up
  // with the SPRAM read data.
  logic             tag0_vld;
  owner_t           tag0_own;
  logic             tag1_vld;
  owner_t           tag1_own;

  // Arbitration and next owner/burst state; grants are suppressed in reset.
  always_comb begin
    grant_a        = 1'b0;
    grant_b        = 1'b0;
    burst_cnt_nxt  = burst_cnt;
    last_owner_nxt = last_owner;

    if (reset) begin
      if (a_req && (!b_req || (last_owner == OWNER_B) ||
                    (burst_cnt < CNT_W'(BURST_A)))) begin
        grant_a = 1'b1;
      end else if (b_req) begin
        grant_b = 1'b1;
      end
    end

    // A bursts only count while B is waiting.
    if (!b_req || grant_b) begin
      burst_cnt_nxt = '0;
    end else if (grant_a && (burst_cnt < CNT_W'(BURST_A))) begin
      burst_cnt_nxt = burst_cnt + CNT_W'(1);
    end

    if (grant_a) begin
      last_owner_nxt = OWNER_A;
    end else if (grant_b) begin
      last_owner_nxt = OWNER_B;
    end
  end

  // Owner and burst state; reset leaves B as last owner so A wins first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_owner <= OWNER_B;
      burst_cnt  <= '0;
    end else begin
      last_owner <= last_owner_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  // SPRAM request stage: capture the granted port; idle cycles hold addr/data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sram_addr    <= '0;
      sram_data_in <= '0;
      sram_wren    <= 1'b0;
    end else if (grant_a) begin
      sram_addr    <= a_addr;
      sram_data_in <= a_wdata;
      sram_wren    <= a_we;
    end else if (grant_b) begin
      sram_addr    <= b_addr;
      sram_data_in <= b_wdata;
      sram_wren    <= b_we;
    end else begin
      sram_wren    <= 1'b0;
    end
  end

  // Two-deep read tag shift register; reset drops all in-flight reads.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag0_vld <= 1'b0;
      tag0_own <= OWNER_A;
      tag1_vld <= 1'b0;
      tag1_own <= OWNER_A;
    end else begin
      tag0_vld <= (grant_a && !a_we) || (grant_b && !b_we);
      tag0_own <= grant_b ? OWNER_B : OWNER_A;
      tag1_vld <= tag0_vld;
      tag1_own <= tag0_own;
    end
  end

  assign a_gnt    = grant_a;
  assign b_gnt    = grant_b;
  assign a_rvalid = tag1_vld && (tag1_own == OWNER_A);
  assign b_rvalid = tag1_vld && (tag1_own == OWNER_B);
  assign a_rdata  = sram_data_out;
  assign b_rdata  = sram_data_out;

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: behavioural SPRAM, reference memory and a read
// scoreboard checked every cycle.
module tb_spram_arbiter;

  logic        clock;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic [15:0] sram_addr, sram_data_in, sram_data_out;
  logic        sram_wren;

  typedef struct {
    logic        port_b;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] mem [0:65535];
  int          cyc;
  int          total;
  int          passed;
  int          failed;

  spram_arbiter #(.BURST_A(4), .ADDR_W(16), .DATA_W(16)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .sram_addr(sram_addr), .sram_data_in(sram_data_in),
    .sram_wren(sram_wren), .sram_data_out(sram_data_out)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  // Synchronous SPRAM model: registered read, write on WREN.
  always @(posedge clock) begin
    if (sram_wren) mem[sram_addr] <= sram_data_in;
    sram_data_out <= mem[sram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wd);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wd);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
  endtask

  // One clock: check grants and read returns at negedge, stage 1 after posedge.
  task automatic cycle(input logic ea, input logic eb);
    exp_t        e;
    logic        exp_v;
    logic [1:0]  exp_rv;
    logic        g_v, g_we;
    logic [15:0] g_addr, g_wd;
    @(negedge clock);
    while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
    exp_v  = (q.size() > 0) && (q[0].due == cyc);
    exp_rv = exp_v ? (q[0].port_b ? 2'b01 : 2'b10) : 2'b00;
    chk("rvalid_ab", 32'({a_rvalid, b_rvalid}), 32'(exp_rv));
    if (exp_v) begin
      e = q.pop_front();
      chk(e.port_b ? "b_rdata" : "a_rdata", 32'(e.port_b ? b_rdata : a_rdata), 32'(e.data));
    end
    chk("gnt_ab", 32'({a_gnt, b_gnt}), 32'({ea, eb}));
    g_v = 1'b0; g_we = 1'b0; g_addr = '0; g_wd = '0;
    if (ea) begin
      g_v = 1'b1; g_we = a_we; g_addr = a_addr; g_wd = a_wdata;
      if (a_we) ref_mem[a_addr] = a_wdata;
      else q.push_back('{1'b0, ref_mem[a_addr], cyc + 2});
    end else if (eb) begin
      g_v = 1'b1; g_we = b_we; g_addr = b_addr; g_wd = b_wdata;
      if (b_we) ref_mem[b_addr] = b_wdata;
      else q.push_back('{1'b1, ref_mem[b_addr], cyc + 2});
    end
    @(posedge clock);
    #1;
    cyc++;
    chk("sram_wren", 32'(sram_wren), 32'(g_v && g_we));
    if (g_v) chk("sram_addr", 32'(sram_addr), 32'(g_addr));
    if (g_v && g_we) chk("sram_data_in", 32'(sram_data_in), 32'(g_wd));
  endtask

  task automatic idle(input int n);
    set_a(1'b0, 1'b0, 16'h0000, 16'h0000);
    set_b(1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  initial begin
    cyc = 0; total = 0; passed = 0; failed = 0;
    reset = 1'b0;
    set_a(1'b0, 1'b0, 16'h0000, 16'h0000);
    set_b(1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) @(posedge clock);
    #1;
    a_req = 1'b1; b_req = 1'b1;
    #1;
    chk("rst_sram_addr", 32'(sram_addr), 32'h0);
    chk("rst_sram_data_in", 32'(sram_data_in), 32'h0);
    chk("rst_sram_wren", 32'(sram_wren), 32'h0);
    chk("rst_gnt", 32'({a_gnt, b_gnt}), 32'h0);
    chk("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'h0);
    a_req = 1'b0; b_req = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;

    // A-only write then read
    set_a(1'b1, 1'b1, 16'h0010, 16'h1234); cycle(1'b1, 1'b0);
    set_a(1'b1, 1'b0, 16'h0010, 16'h0000); cycle(1'b1, 1'b0);
    idle(3);

    // Preload for routing: A writes 0x0001, B writes 0x0002
    set_a(1'b1, 1'b1, 16'h0001, 16'hAAAA); cycle(1'b1, 1'b0);
    set_a(1'b0, 1'b0, 16'h0000, 16'h0000);
    set_b(1'b1, 1'b1, 16'h0002, 16'h5555); cycle(1'b0, 1'b1);
    idle(2);

    // Alternating A/B reads
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        set_b(1'b0, 1'b0, 16'h0000, 16'h0000);
        set_a(1'b1, 1'b0, 16'h0001, 16'h0000); cycle(1'b1, 1'b0);
      end else begin
        set_a(1'b0, 1'b0, 16'h0000, 16'h0000);
        set_b(1'b1, 1'b0, 16'h0002, 16'h0000); cycle(1'b0, 1'b1);
      end
    end
    idle(3);

    // Contention for 20 cycles: A,A,A,A,B repeating
    set_a(1'b1, 1'b0, 16'h0010, 16'h0000);
    set_b(1'b1, 1'b0, 16'h0002, 16'h0000);
    for (int i = 0; i < 20; i++) cycle((i % 5) != 4, (i % 5) == 4);
    idle(3);

    // Cross-port write then read at the top address
    set_b(1'b1, 1'b1, 16'hFFFF, 16'hBEEF); cycle(1'b0, 1'b1);
    set_b(1'b0, 1'b0, 16'h0000, 16'h0000);
    set_a(1'b1, 1'b0, 16'hFFFF, 16'h0000); cycle(1'b1, 1'b0);
    idle(3);

    // One-cycle B request while A streams; burst count must clear after
    set_a(1'b1, 1'b0, 16'h0001, 16'h0000);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    set_b(1'b1, 1'b0, 16'h0002, 16'h0000); cycle(1'b1, 1'b0);
    set_b(1'b0, 1'b0, 16'h0000, 16'h0000); cycle(1'b1, 1'b0);
    set_b(1'b1, 1'b0, 16'h0002, 16'h0000);
    for (int i = 0; i < 5; i++) cycle(i != 4, i == 4);
    idle(3);

    // Reset with two A reads in flight
    set_a(1'b1, 1'b0, 16'h0010, 16'h0000); cycle(1'b1, 1'b0);
    set_a(1'b1, 1'b0, 16'h0001, 16'h0000); cycle(1'b1, 1'b0);
    reset = 1'b0;
    #1;
    chk("mid_rst_sram_wren", 32'(sram_wren), 32'h0);
    chk("mid_rst_sram_addr", 32'(sram_addr), 32'h0);
    chk("mid_rst_gnt", 32'({a_gnt, b_gnt}), 32'h0);
    chk("mid_rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'h0);
    q.delete();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    set_a(1'b0, 1'b0, 16'h0000, 16'h0000);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
    set_a(1'b1, 1'b0, 16'h0010, 16'h0000);
    set_b(1'b1, 1'b0, 16'h0002, 16'h0000);
    cycle(1'b1, 1'b0);
    idle(4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
